// File: rtl/glitcher_pkg.sv
// Shared definitions for the voltage-glitch generator.
//   - state_e      : FSM state encoding (2 bits)
//   - CNT_W        : width of the lock, pulse and debounce counters
//   - *_CYCLES_DEF : default timing parameters for vcc_glitcher
package glitcher_pkg;

  localparam int CNT_W = 16;

  localparam int LOCK_CYCLES_DEF     = 64;
  localparam int PULSE_CYCLES_DEF    = 10;
  localparam int DEBOUNCE_CYCLES_DEF = 65535;

  typedef enum logic [1:0] {
    ST_LOCKING = 2'd0,  // waiting for the modelled clock to become ready
    ST_IDLE    = 2'd1,  // armed, waiting for a button edge
    ST_GLITCH  = 2'd2,  // supply dropped
    ST_HOLDOFF = 2'd3   // debouncing the button after a glitch
  } state_e;

endpackage : glitcher_pkg

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous input followed by a rising-edge
// detector built on a registered copy of the synchronized value.
//
// Ports:
//   i_clk  : system clock
//   i_rst  : synchronous active-high reset
//   i_d    : asynchronous input
//   o_sync : synchronized level
//   o_rise : one-cycle high when o_sync goes 0 -> 1 (decoded from flops only)
module sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_sync,
  output logic o_rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = i_d;
    sync_d = meta_q;
    // The previous-value flop follows the synchronized level every cycle,
    // regardless of what the consumer is doing with the edge.
    prev_d = sync_q;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign o_sync = sync_q;
  assign o_rise = sync_q & ~prev_q;

endmodule : sync_edge

// File: rtl/vcc_glitcher.sv
// Voltage-glitch generator. Holds the target supply enable (o_glitch) high
// while armed and drops it for PULSE_CYCLES cycles on each debounced press of
// i_pulse. Also provides a lock flag, a divided monitor clock, status LEDs and
// a count of issued glitches.
//
// Ports:
//   i_clk        : system clock
//   i_clk_reset  : synchronous active-high reset
//   i_glitch     : switch, 1 = supply enabled and glitching armed (async)
//   i_pulse      : button, rising edge requests one glitch (async)
//   o_clk        : i_clk / 2 monitor clock
//   o_clk_locked : high once LOCK_CYCLES cycles have elapsed after reset
//   o_clk_led    : copy of o_clk_locked
//   o_glitch     : target supply enable, low while a glitch is in progress
//   o_glitch_led : high while locked and the switch is on
//   o_counter    : number of glitches issued, wraps at 16 bits
module vcc_glitcher
  import glitcher_pkg::*;
#(
  parameter int LOCK_CYCLES     = LOCK_CYCLES_DEF,
  parameter int PULSE_CYCLES    = PULSE_CYCLES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic        i_clk,
  input  logic        i_clk_reset,
  input  logic        i_glitch,
  input  logic        i_pulse,
  output logic        o_clk,
  output logic        o_clk_locked,
  output logic        o_clk_led,
  output logic        o_glitch,
  output logic        o_glitch_led,
  output logic [15:0] o_counter
);

  // Terminal counts: each phase counts from 0 up to N-1, giving N cycles.
  localparam logic [CNT_W-1:0] LOCK_LAST     = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST    = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Synchronized inputs
  logic g_s;
  logic g_rise_unused;
  logic p_s;
  logic p_rise;

  sync_edge u_sync_pulse (
    .i_clk  (i_clk),
    .i_rst  (i_clk_reset),
    .i_d    (i_pulse),
    .o_sync (p_s),
    .o_rise (p_rise)
  );

  sync_edge u_sync_glitch (
    .i_clk  (i_clk),
    .i_rst  (i_clk_reset),
    .i_d    (i_glitch),
    .o_sync (g_s),
    .o_rise (g_rise_unused)
  );

  // State
  state_e           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;      // shared by lock/pulse/debounce phases
  logic             locked_q,  locked_d;
  logic             done_q,    done_d;     // pulse finished last cycle
  logic [15:0]      counter_q, counter_d;
  logic             glitch_q,  glitch_d;
  logic             gled_q,    gled_d;
  logic             clk_q,     clk_d;

  always_comb begin
    // NOTE: every variable gets a default before the case statement so no
    // path leaves it unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    locked_d = locked_q;
    done_d   = 1'b0;

    // The glitch count is bumped one cycle after the FSM leaves GLITCH so it
    // changes on the same edge that o_glitch returns high.
    counter_d = done_q ? counter_q + 16'd1 : counter_q;

    clk_d = ~clk_q;

    // Supply enable looks at the current state only; once GLITCH is entered
    // the pulse runs to completion whatever the switch does.
    glitch_d = locked_q & g_s & (state_q != ST_GLITCH);
    gled_d   = locked_q & g_s;

    unique case (state_q)
      ST_LOCKING: begin
        if (cnt_q == LOCK_LAST) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          locked_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_IDLE: begin
        // Edges seen while disarmed are simply dropped.
        if (p_rise && g_s) begin
          state_d = ST_GLITCH;
          cnt_d   = '0;
        end
      end

      ST_GLITCH: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = ST_HOLDOFF;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_HOLDOFF: begin
        // Require DEBOUNCE_CYCLES consecutive low samples; any high sample
        // restarts the count, so a long press yields one glitch.
        if (p_s) begin
          cnt_d = '0;
        end else if (cnt_q == DEBOUNCE_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_LOCKING;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_clk_reset) begin
      state_q   <= ST_LOCKING;
      cnt_q     <= '0;
      locked_q  <= 1'b0;
      done_q    <= 1'b0;
      counter_q <= '0;
      glitch_q  <= 1'b0;
      gled_q    <= 1'b0;
      clk_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      locked_q  <= locked_d;
      done_q    <= done_d;
      counter_q <= counter_d;
      glitch_q  <= glitch_d;
      gled_q    <= gled_d;
      clk_q     <= clk_d;
    end
  end

  assign o_clk        = clk_q;
  assign o_clk_locked = locked_q;
  assign o_clk_led    = locked_q;
  assign o_glitch     = glitch_q;
  assign o_glitch_led = gled_q;
  assign o_counter    = counter_q;

endmodule : vcc_glitcher

// File: tb/tb_vcc_glitcher.sv
// Self-checking bench for vcc_glitcher: directed scenarios plus randomized
// button/switch activity, compared every cycle against a timestamp-based
// reference model.
module tb_vcc_glitcher;

  localparam int L = 64;
  localparam int P = 10;
  localparam int D = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sw  = 1'b0;
  logic        btn = 1'b0;
  logic        o_clk, o_clk_locked, o_clk_led, o_glitch, o_glitch_led;
  logic [15:0] o_counter;

  vcc_glitcher #(
    .LOCK_CYCLES     (L),
    .PULSE_CYCLES    (P),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .i_clk        (clk),
    .i_clk_reset  (rst),
    .i_glitch     (sw),
    .i_pulse      (btn),
    .o_clk        (o_clk),
    .o_clk_locked (o_clk_locked),
    .o_clk_led    (o_clk_led),
    .o_glitch     (o_glitch),
    .o_glitch_led (o_glitch_led),
    .o_counter    (o_counter)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. Time is measured in edges since reset release (n).
  // Inputs are recorded as sampled at each edge; the synchronized level seen
  // by the logic at edge n is the sample taken two edges earlier. A glitch is
  // described by the edge it was accepted on (pstart); everything else follows
  // arithmetically from that timestamp.
  // ---------------------------------------------------------------------------
  bit          ph[3];  // [0] newest button sample
  bit          gh[3];
  int          n;
  int          pstart;
  int          idle_from;
  int          low_run;
  bit          busy;
  bit          m_clk, m_locked, m_glitch, m_led;
  logic [15:0] m_cnt;

  always @(posedge clk) begin
    bit ps_b, pp_b, gs_b, in_pulse;
    if (rst) begin
      ph = '{default: 1'b0};
      gh = '{default: 1'b0};
      n = 0; pstart = -1000; idle_from = L + 1; low_run = 0; busy = 0;
      m_clk = 0; m_locked = 0; m_glitch = 0; m_led = 0; m_cnt = '0;
    end else begin
      ps_b = ph[1];
      pp_b = ph[2];
      gs_b = gh[1];
      n++;
      // Was the supply being held low during the cycle ending at this edge?
      in_pulse = (n - 1 >= pstart) && (n - 1 <= pstart + P - 1);
      m_glitch = m_locked & gs_b & ~in_pulse;
      m_led    = m_locked & gs_b;
      m_clk    = ~m_clk;
      if (n == pstart + P + 1) m_cnt = m_cnt + 16'd1;
      if (busy && n >= pstart + P + 1) begin
        low_run = ps_b ? 0 : low_run + 1;
        if (low_run == D) begin
          busy = 0;
          idle_from = n + 1;
        end
      end else if (!busy && n >= idle_from && ps_b && !pp_b && gs_b) begin
        busy = 1;
        pstart = n;
        low_run = 0;
      end
      if (n >= L) m_locked = 1;
      ph[2] = ph[1]; ph[1] = ph[0]; ph[0] = btn;
      gh[2] = gh[1]; gh[1] = gh[0]; gh[0] = sw;
    end
  end

  // Cycle-by-cycle comparison and a fall monitor used by the directed tests.
  int fall_cnt = 0;
  logic prev_glitch = 1'b0;

  always @(negedge clk) begin
    check("clk",        {31'b0, o_clk},        {31'b0, m_clk});
    check("locked",     {31'b0, o_clk_locked}, {31'b0, m_locked});
    check("clk_led",    {31'b0, o_clk_led},    {31'b0, m_locked});
    check("glitch",     {31'b0, o_glitch},     {31'b0, m_glitch});
    check("glitch_led", {31'b0, o_glitch_led}, {31'b0, m_led});
    check("counter",    {16'b0, o_counter},    {16'b0, m_cnt});
    if (prev_glitch && !o_glitch) fall_cnt++;
    prev_glitch = o_glitch;
  end

  task automatic tick(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  // Counts edges after reset release until lock is seen.
  task automatic measure_lock(input string tag);
    int k;
    k = 0;
    while (k < 4 * L && !o_clk_locked) begin
      @(negedge clk);
      k++;
    end
    check(tag, k, L);
  endtask

  int base_fall;
  int k;
  int lows;
  int high_seen;

  initial begin
    // ---- reset state --------------------------------------------------------
    rst = 1'b1; sw = 1'b0; btn = 1'b0;
    tick(2);
    check("rst_outputs", {26'b0, o_clk, o_clk_locked, o_clk_led, o_glitch, o_glitch_led, 1'b0},
          32'd0);
    check("rst_counter", {16'b0, o_counter}, 32'd0);
    rst = 1'b0;
    measure_lock("lock_latency");

    // ---- single glitch: latency and width ----------------------------------
    sw = 1'b1;
    tick(5);
    btn = 1'b1;
    k = 0;
    while (k < 20 && o_glitch) begin
      @(negedge clk);
      k++;
    end
    check("fall_latency", k, 4);
    lows = 1;
    while (lows < 40) begin
      @(negedge clk);
      if (o_glitch) break;
      lows++;
    end
    check("pulse_width", lows, P);
    check("count_after_1", {16'b0, o_counter}, 32'd1);
    tick(20 - 4 - P);
    btn = 1'b0;
    tick(D + 20);

    // ---- long press gives exactly one glitch --------------------------------
    base_fall = fall_cnt;
    btn = 1'b1;
    tick(3 * D);
    btn = 1'b0;
    tick(5);
    check("long_press_falls", fall_cnt - base_fall, 1);
    check("count_after_long", {16'b0, o_counter}, 32'd2);
    tick(D + 5);
    base_fall = fall_cnt;
    btn = 1'b1;
    tick(20);
    btn = 1'b0;
    tick(10);
    check("repress_falls", fall_cnt - base_fall, 1);
    check("count_after_repress", {16'b0, o_counter}, 32'd3);
    tick(D + 5);

    // ---- disarmed press ----------------------------------------------------
    sw = 1'b0;
    tick(5);
    base_fall = fall_cnt;
    high_seen = 0;
    btn = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (o_glitch || o_glitch_led) high_seen++;
    end
    btn = 1'b0;
    tick(20);
    check("disarmed_high", high_seen, 0);
    check("disarmed_falls", fall_cnt - base_fall, 0);
    check("disarmed_count", {16'b0, o_counter}, 32'd3);

    // ---- button held through reset and lock --------------------------------
    sw = 1'b1;
    btn = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    base_fall = fall_cnt;
    tick(L + 50);
    check("held_falls", fall_cnt - base_fall, 0);
    check("held_count", {16'b0, o_counter}, 32'd0);
    check("held_glitch_high", {31'b0, o_glitch}, 32'd1);
    btn = 1'b0;
    tick(10);

    // ---- reset in the middle of a pulse ------------------------------------
    btn = 1'b1;
    k = 0;
    while (k < 20 && o_glitch) begin
      @(negedge clk);
      k++;
    end
    tick(4);  // fifth low cycle is now on the output
    check("mid_pulse_low", {31'b0, o_glitch}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_outputs", {26'b0, o_clk, o_clk_locked, o_clk_led, o_glitch, o_glitch_led, 1'b0},
          32'd0);
    check("mid_rst_counter", {16'b0, o_counter}, 32'd0);
    btn = 1'b0;
    rst = 1'b0;
    measure_lock("relock_latency");
    tick(5);
    check("relock_counter", {16'b0, o_counter}, 32'd0);

    // ---- randomized activity against the model -----------------------------
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1;
        tick($urandom_range(1, 2));
        rst = 1'b0;
      end
      sw  = ($urandom_range(0, 3) != 0);
      btn = 1'b1;
      tick($urandom_range(1, 30));
      if ($urandom_range(0, 3) == 0) sw = ~sw;
      tick($urandom_range(0, 10));
      btn = 1'b0;
      tick($urandom_range(1, 2 * D));
      if ($urandom_range(0, 5) == 0) begin
        btn = 1'b1;
        tick(1);
        btn = 1'b0;
        tick($urandom_range(1, 8));
      end
    end
    tick(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_vcc_glitcher
